// File: rtl/axil_pkg.sv
// Shared types for the fabric-side AXI4-Lite command master.
//   axil_resp_e       : AXI4-Lite BRESP/RRESP encodings
//   axil_mst_state_e  : command master FSM states
//   AXIL_PROT_DEFAULT : value driven on awprot/arprot
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axil_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_RSP   = 3'd5
  } axil_mst_state_e;

  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle between one master and one slave.
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where both valid and ready are high; once valid is raised the sender keeps
// it and its payload stable until that edge (this master only breaks that
// on a watchdog abort), and ready may be raised before, with or after valid.
// Modports: master drives aw*/w*/ar* payload+valid and bready/rready;
// slave drives the ready signals of those channels and b*/r* payload+valid.
interface axil_if #(
  parameter int ADDRW = 7,
  parameter int DATAW = 32
);
  localparam int STRBW = DATAW / 8;

  logic [ADDRW-1:0] awaddr;
  logic [2:0]       awprot;
  logic             awvalid;
  logic             awready;

  logic [DATAW-1:0] wdata;
  logic [STRBW-1:0] wstrb;
  logic             wvalid;
  logic             wready;

  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;

  logic [ADDRW-1:0] araddr;
  logic [2:0]       arprot;
  logic             arvalid;
  logic             arready;

  logic [DATAW-1:0] rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );

endinterface

// File: rtl/axil_wdog.sv
// Saturating transaction watchdog.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the count (command accepted)
//   en        : count this cycle (transaction in flight)
//   expired_o : high in the cycle whose increment brings the count to
//               TIMEOUT_CYC, or any later enabled cycle; always 0 when
//               TIMEOUT_CYC is 0
// The caller registers its reaction, so the abort becomes visible on the
// bus exactly one cycle after the count reaches the limit.
module axil_wdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_o
);

  localparam int CNTW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TIMEOUT_CYC);
  localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNTW'(TIMEOUT_CYC - 1) : '0;

  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (TIMEOUT_CYC != 0) && en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a command/response
// handshake.
//   clk100, rst     : clock, synchronous active-high reset
//   cmd_*           : command in (valid/ready, wr, addr, wdata, wstrb)
//   rsp_*           : response out (valid/ready, rdata, resp, timeout)
//   dbg_state_o     : current FSM state
//   axil_m          : AXI4-Lite master port
// Every output is a flop: the FSM computes next values for all of them in
// one combinational block and a single register block loads them.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDRW       = 7,
  parameter int DATAW       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_wr_i,
  input  logic [ADDRW-1:0]   cmd_addr_i,
  input  logic [DATAW-1:0]   cmd_wdata_i,
  input  logic [DATAW/8-1:0] cmd_wstrb_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DATAW-1:0]   rsp_rdata_o,
  output logic [1:0]         rsp_resp_o,
  output logic               rsp_timeout_o,
  output axil_mst_state_e    dbg_state_o,
  axil_if.master             axil_m
);

  localparam int STRBW = DATAW / 8;

  axil_mst_state_e  state_q, state_d;
  logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic             arvalid_q, arvalid_d, rready_q, rready_d;
  logic             cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  axil_resp_e       rsp_resp_q, rsp_resp_d;
  logic [DATAW-1:0] rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
  logic [STRBW-1:0] wstrb_q, wstrb_d;
  logic [ADDRW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;

  logic cmd_accept, wd_en, wd_expired, abort;
  logic aw_pend, w_pend;

  assign cmd_accept = cmd_valid_i && cmd_ready_q;
  assign wd_en = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                 (state_q == ST_RD_AR) || (state_q == ST_RD_R);

  // Address/data channels still waiting for their handshake after this edge.
  assign aw_pend = awvalid_q && !axil_m.awready;
  assign w_pend  = wvalid_q && !axil_m.wready;

  axil_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk       (clk100),
    .rst       (rst),
    .clr       (cmd_accept),
    .en        (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    abort         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          cmd_ready_d = 1'b0;
          if (cmd_wr_i) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr_i;
            wdata_d   = cmd_wdata_i;
            wstrb_d   = cmd_wstrb_i;
          end else begin
            state_d   = ST_RD_AR;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr_i;
          end
        end
      end
      ST_WR: begin
        if (wd_expired) begin
          abort = 1'b1;
        end else begin
          awvalid_d = aw_pend;
          wvalid_d  = w_pend;
          if (!aw_pend && !w_pend) begin
            state_d  = ST_WR_B;
            bready_d = 1'b1;
          end
        end
      end
      ST_WR_B: begin
        // A beat that handshakes in the expiry cycle was really taken from
        // the slave, so it is reported rather than overridden by the abort.
        if (bready_q && axil_m.bvalid) begin
          state_d       = ST_RSP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = axil_resp_e'(axil_m.bresp);
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      ST_RD_AR: begin
        if (wd_expired) begin
          abort = 1'b1;
        end else if (arvalid_q && axil_m.arready) begin
          state_d   = ST_RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_R: begin
        if (rready_q && axil_m.rvalid) begin
          state_d       = ST_RSP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = axil_resp_e'(axil_m.rresp);
          rsp_rdata_d   = axil_m.rdata;
          rsp_timeout_d = 1'b0;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase

    // Watchdog abort: drop every bus valid/ready so late B/R beats are never
    // taken, and hand a SLVERR timeout response to the command side.
    if (abort) begin
      state_d       = ST_RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_resp_q    <= OKAY;
      rsp_rdata_q   <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_resp_o     = rsp_resp_q;
  assign rsp_timeout_o  = rsp_timeout_q;
  assign dbg_state_o    = state_q;

  assign axil_m.awaddr  = awaddr_q;
  assign axil_m.awprot  = AXIL_PROT_DEFAULT;
  assign axil_m.awvalid = awvalid_q;
  assign axil_m.wdata   = wdata_q;
  assign axil_m.wstrb   = wstrb_q;
  assign axil_m.wvalid  = wvalid_q;
  assign axil_m.bready  = bready_q;
  assign axil_m.araddr  = araddr_q;
  assign axil_m.arprot  = AXIL_PROT_DEFAULT;
  assign axil_m.arvalid = arvalid_q;
  assign axil_m.rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a hand-driven AXI4-Lite slave.
module tb_axil_cmd_master;
  import axil_pkg::*;

  localparam int ADDRW = 7;
  localparam int DATAW = 32;
  localparam int TO    = 16;

  // ---------------- clock / reset ----------------
  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;
  logic rst;

  logic               cmd_valid, cmd_ready, cmd_wr;
  logic [ADDRW-1:0]   cmd_addr;
  logic [DATAW-1:0]   cmd_wdata;
  logic [DATAW/8-1:0] cmd_wstrb;
  logic               rsp_valid, rsp_ready, rsp_timeout;
  logic [DATAW-1:0]   rsp_rdata;
  logic [1:0]         rsp_resp;
  axil_mst_state_e    dbg_state;

  axil_if #(.ADDRW(ADDRW), .DATAW(DATAW)) axil ();

  axil_cmd_master #(.ADDRW(ADDRW), .DATAW(DATAW), .TIMEOUT_CYC(TO)) dut (
    .clk100        (clk100),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_wr_i      (cmd_wr),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .cmd_wstrb_i   (cmd_wstrb),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_resp_o    (rsp_resp),
    .rsp_timeout_o (rsp_timeout),
    .dbg_state_o   (dbg_state),
    .axil_m        (axil)
  );

  // ---------------- slave-side observers ----------------
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw0, w0, b0, ar0, r0;
  logic [31:0] mem [0:31];

  always @(posedge clk100) begin
    if (axil.awvalid && axil.awready) aw_cnt <= aw_cnt + 1;
    if (axil.wvalid && axil.wready) begin
      w_cnt <= w_cnt + 1;
      mem[axil.awaddr[6:2]] <= axil.wdata;
    end
    if (axil.bvalid && axil.bready) b_cnt <= b_cnt + 1;
    if (axil.arvalid && axil.arready) ar_cnt <= ar_cnt + 1;
    if (axil.rvalid && axil.rready) r_cnt <= r_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DATAW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] resp, input logic to);
    logic [DATAW-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp_rdata"}, rsp_rdata, e);
    check({tag, "_rsp_resp"}, rsp_resp, resp);
    check({tag, "_rsp_timeout"}, rsp_timeout, to);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic slave_idle();
    axil.awready = 1'b0; axil.wready = 1'b0;
    axil.bvalid = 1'b0;  axil.bresp = 2'b00;
    axil.arready = 1'b0; axil.rvalid = 1'b0;
    axil.rdata = '0;     axil.rresp = 2'b00;
  endtask

  task automatic snap();
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
  endtask

  // Presents a command in the current cycle; returns in the following cycle.
  task automatic accept(input logic wr, input logic [ADDRW-1:0] addr,
                        input logic [DATAW-1:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    check("cmd_ready_at_accept", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    check({tag, "_cmd_ready_during_rsp"}, cmd_ready, 1'b0);
    tick();
    rsp_ready = 1'b0;
    check({tag, "_cmd_ready_after"}, cmd_ready, 1'b1);
    check({tag, "_rsp_valid_after"}, rsp_valid, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    slave_idle();
    tick(); tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_awvalid", axil.awvalid, 1'b0);
    check("rst_wvalid", axil.wvalid, 1'b0);
    check("rst_bready", axil.bready, 1'b0);
    check("rst_arvalid", axil.arvalid, 1'b0);
    check("rst_rready", axil.rready, 1'b0);
    check("rst_awaddr", axil.awaddr, 7'h00);
    check("rst_wdata", axil.wdata, 32'h0);
    check("rst_wstrb", axil.wstrb, 4'h0);
    check("rst_araddr", axil.araddr, 7'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_resp", rsp_resp, 2'b00);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    rst = 1'b0;
    tick();

    // 1: zero-wait write 0x04 <- 0x11
    snap();
    axil.awready = 1'b1; axil.wready = 1'b1;
    accept(1'b1, 7'h04, 32'h0000_0011, 4'hF);
    check("w1_awvalid_n1", axil.awvalid, 1'b1);
    check("w1_wvalid_n1", axil.wvalid, 1'b1);
    check("w1_awaddr", axil.awaddr, 7'h04);
    check("w1_wdata", axil.wdata, 32'h11);
    check("w1_wstrb", axil.wstrb, 4'hF);
    check("w1_awprot", axil.awprot, 3'b000);
    check("w1_cmd_ready_busy", cmd_ready, 1'b0);
    tick();
    axil.awready = 1'b0; axil.wready = 1'b0;
    check("w1_awvalid_n2", axil.awvalid, 1'b0);
    check("w1_wvalid_n2", axil.wvalid, 1'b0);
    check("w1_bready_n2", axil.bready, 1'b1);
    axil.bvalid = 1'b1; axil.bresp = 2'b00;
    exp_q.push_back(32'h0);
    tick();
    axil.bvalid = 1'b0;
    check_rsp("w1", 2'b00, 1'b0);
    check("w1_bready_n3", axil.bready, 1'b0);
    check("w1_one_aw", aw_cnt - aw0, 1);
    check("w1_one_w", w_cnt - w0, 1);
    check("w1_one_b", b_cnt - b0, 1);
    finish_rsp("w1");

    // Read back 0x04 from the slave register
    snap();
    axil.arready = 1'b1;
    accept(1'b0, 7'h04, 32'h0, 4'h0);
    check("rb_arvalid", axil.arvalid, 1'b1);
    check("rb_araddr", axil.araddr, 7'h04);
    check("rb_arprot", axil.arprot, 3'b000);
    tick();
    axil.arready = 1'b0;
    check("rb_arvalid_drop", axil.arvalid, 1'b0);
    check("rb_rready", axil.rready, 1'b1);
    axil.rvalid = 1'b1; axil.rdata = mem[1]; axil.rresp = 2'b00;
    exp_q.push_back(32'h0000_0011);
    tick();
    axil.rvalid = 1'b0; axil.rdata = '0;
    check_rsp("rb", 2'b00, 1'b0);
    check("rb_one_r", r_cnt - r0, 1);
    finish_rsp("rb");

    // 2: read 0x08, arready after 3 cycles, rvalid after 2 more
    snap();
    accept(1'b0, 7'h08, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      check("r2_arvalid_held", axil.arvalid, 1'b1);
      check("r2_araddr_held", axil.araddr, 7'h08);
      tick();
    end
    check("r2_arvalid_n4", axil.arvalid, 1'b1);
    axil.arready = 1'b1;
    tick();
    axil.arready = 1'b0;
    check("r2_arvalid_drop", axil.arvalid, 1'b0);
    check("r2_rready_n5", axil.rready, 1'b1);
    check("r2_one_ar", ar_cnt - ar0, 1);
    tick();
    check("r2_rready_n6", axil.rready, 1'b1);
    check("r2_no_rsp_yet", rsp_valid, 1'b0);
    tick();
    axil.rvalid = 1'b1; axil.rdata = 32'hCAFE_0008; axil.rresp = 2'b00;
    exp_q.push_back(32'hCAFE_0008);
    tick();
    axil.rvalid = 1'b0; axil.rdata = '0;
    check_rsp("r2", 2'b00, 1'b0);
    finish_rsp("r2");

    // 3a: awready one cycle before wready, EXOKAY response
    snap();
    accept(1'b1, 7'h14, 32'h22, 4'hF);
    axil.awready = 1'b1;
    tick();
    axil.awready = 1'b0; axil.wready = 1'b1;
    check("w3a_awvalid_drop", axil.awvalid, 1'b0);
    check("w3a_wvalid_held", axil.wvalid, 1'b1);
    check("w3a_bready_early", axil.bready, 1'b0);
    tick();
    axil.wready = 1'b0;
    check("w3a_wvalid_drop", axil.wvalid, 1'b0);
    check("w3a_bready", axil.bready, 1'b1);
    axil.bvalid = 1'b1; axil.bresp = 2'b01;
    exp_q.push_back(32'h0);
    tick();
    axil.bvalid = 1'b0; axil.bresp = 2'b00;
    check_rsp("w3a", 2'b01, 1'b0);
    check("w3a_one_aw", aw_cnt - aw0, 1);
    check("w3a_one_w", w_cnt - w0, 1);
    check("w3a_one_b", b_cnt - b0, 1);
    finish_rsp("w3a");

    // 3b: wready one cycle before awready
    snap();
    accept(1'b1, 7'h18, 32'h33, 4'h3);
    axil.wready = 1'b1;
    tick();
    axil.wready = 1'b0; axil.awready = 1'b1;
    check("w3b_wvalid_drop", axil.wvalid, 1'b0);
    check("w3b_awvalid_held", axil.awvalid, 1'b1);
    check("w3b_wstrb", axil.wstrb, 4'h3);
    tick();
    axil.awready = 1'b0;
    check("w3b_awvalid_drop", axil.awvalid, 1'b0);
    check("w3b_bready", axil.bready, 1'b1);
    axil.bvalid = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    axil.bvalid = 1'b0;
    check_rsp("w3b", 2'b00, 1'b0);
    check("w3b_one_aw", aw_cnt - aw0, 1);
    check("w3b_one_w", w_cnt - w0, 1);
    check("w3b_one_b", b_cnt - b0, 1);
    finish_rsp("w3b");

    // 3c: both ready together, DECERR response
    snap();
    accept(1'b1, 7'h1C, 32'h44, 4'hF);
    axil.awready = 1'b1; axil.wready = 1'b1;
    tick();
    axil.awready = 1'b0; axil.wready = 1'b0;
    check("w3c_awvalid_drop", axil.awvalid, 1'b0);
    check("w3c_wvalid_drop", axil.wvalid, 1'b0);
    check("w3c_bready", axil.bready, 1'b1);
    axil.bvalid = 1'b1; axil.bresp = 2'b11;
    exp_q.push_back(32'h0);
    tick();
    axil.bvalid = 1'b0; axil.bresp = 2'b00;
    check_rsp("w3c", 2'b11, 1'b0);
    check("w3c_one_b", b_cnt - b0, 1);
    finish_rsp("w3c");

    // 4: slave never responds; abort visible 17 cycles after accept
    snap();
    accept(1'b1, 7'h20, 32'h55, 4'hF);
    for (int k = 1; k < 16; k++) tick();
    check("to_awvalid_n16", axil.awvalid, 1'b1);
    check("to_wvalid_n16", axil.wvalid, 1'b1);
    check("to_no_rsp_n16", rsp_valid, 1'b0);
    tick();
    check("to_awvalid_n17", axil.awvalid, 1'b0);
    check("to_wvalid_n17", axil.wvalid, 1'b0);
    check("to_bready_n17", axil.bready, 1'b0);
    exp_q.push_back(32'h0);
    check_rsp("to", 2'b10, 1'b1);
    axil.bvalid = 1'b1; axil.bresp = 2'b00;
    tick(); tick();
    axil.bvalid = 1'b0;
    check("to_late_b_ignored", b_cnt - b0, 0);
    check("to_no_aw", aw_cnt - aw0, 0);
    check("to_resp_stable", rsp_resp, 2'b10);
    check("to_timeout_stable", rsp_timeout, 1'b1);
    check("to_rsp_valid_held", rsp_valid, 1'b1);
    finish_rsp("to");

    // 5: response held 5 cycles with a second command pending
    snap();
    axil.arready = 1'b1;
    accept(1'b0, 7'h0C, 32'h0, 4'h0);
    tick();
    axil.arready = 1'b0;
    axil.rvalid = 1'b1; axil.rdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    tick();
    axil.rvalid = 1'b0; axil.rdata = '0;
    check_rsp("hold", 2'b00, 1'b0);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 7'h10;
    cmd_wdata = 32'hA5; cmd_wstrb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rdata", rsp_rdata, 32'h1234_5678);
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    check("hold_cmd_ready_k", cmd_ready, 1'b0);
    tick();
    rsp_ready = 1'b0;
    check("hold_cmd_ready_k1", cmd_ready, 1'b1);
    check("hold_rsp_valid_k1", rsp_valid, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("pend_awvalid", axil.awvalid, 1'b1);
    check("pend_awaddr", axil.awaddr, 7'h10);
    check("pend_cmd_ready", cmd_ready, 1'b0);
    axil.awready = 1'b1; axil.wready = 1'b1;
    tick();
    axil.awready = 1'b0; axil.wready = 1'b0;
    check("pend_in_wr_b", dbg_state, ST_WR_B);
    check("pend_bready", axil.bready, 1'b1);

    // 6: reset pulse while in WR_B
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_bready", axil.bready, 1'b0);
    check("mid_rst_awvalid", axil.awvalid, 1'b0);
    check("mid_rst_wvalid", axil.wvalid, 1'b0);
    check("mid_rst_arvalid", axil.arvalid, 1'b0);
    check("mid_rst_rready", axil.rready, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_awaddr", axil.awaddr, 7'h00);

    // 7: normal read after reset returns the pending command's write
    snap();
    axil.arready = 1'b1;
    accept(1'b0, 7'h10, 32'h0, 4'h0);
    tick();
    axil.arready = 1'b0;
    axil.rvalid = 1'b1; axil.rdata = mem[4]; axil.rresp = 2'b00;
    exp_q.push_back(32'h0000_00A5);
    tick();
    axil.rvalid = 1'b0; axil.rdata = '0;
    check_rsp("post_rst", 2'b00, 1'b0);
    finish_rsp("post_rst");

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
